// File: rtl/neuron_pkg.sv
// Shared encodings and helpers for the neuron datapath.
// The saturate helper works on a wide fixed container so it can serve any DATA_W up to 64.
package neuron_pkg;
  localparam int ACT_NONE  = 0;
  localparam int ACT_RELU  = 1;
  localparam int ACT_LEAKY = 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

  localparam int DRAIN_CYCLES = 3;
  localparam int SAT_W        = 128;

  // Clamp v to the signed w-bit range; ovf reports whether clamping happened.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int w, output logic ovf);
    logic signed [SAT_W-1:0] hi, lo;
    hi  = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
    lo  = -hi - SAT_W'(1);
    ovf = 1'b0;
    saturate = v;
    if (v > hi) begin
      saturate = hi;
      ovf      = 1'b1;
    end else if (v < lo) begin
      saturate = lo;
      ovf      = 1'b1;
    end
  endfunction
endpackage

// File: rtl/neuron_if.sv
// Input activation stream and result stream of one neuron.
interface neuron_if #(parameter int DATA_W = 32);
  logic signed [DATA_W-1:0] x_tdata;
  logic                     x_tvalid;
  logic                     x_tready;
  logic signed [DATA_W-1:0] a_tdata;
  logic                     a_tvalid;
  logic                     a_tready;

  modport slave  (input x_tdata, x_tvalid, a_tready, output x_tready, a_tdata, a_tvalid);
  modport master (output x_tdata, x_tvalid, a_tready, input x_tready, a_tdata, a_tvalid);
endinterface

// File: rtl/neuron_weight_ram.sv
// Simple dual-port weight store: one write port, one registered read port.
module neuron_weight_ram #(
  parameter int DEPTH  = 784,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/neuron_core.sv
// One neuron: streamed x times stored weights, accumulated with bias, clamped and activated.
// Pipeline: RAM read / x capture -> product -> accumulate, tracked by vld_pipe.
module neuron_core import neuron_pkg::*; #(
  parameter int N_INPUTS   = 784,
  parameter int DATA_W     = 32,
  parameter int FRAC_W     = 27,
  parameter int ACTIVATION = 1,
  parameter int ADDR_W     = $clog2(N_INPUTS)
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_aresetn,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] bias,
  input  logic                     w_wr_en,
  input  logic [ADDR_W-1:0]        w_wr_addr,
  input  logic signed [DATA_W-1:0] w_wr_data,
  neuron_if.slave                  axis,
  output logic                     busy,
  output logic                     overflow
);
  localparam int ACC_W  = 2*DATA_W + $clog2(N_INPUTS) + 1;
  localparam int DCNT_W = $clog2(DRAIN_CYCLES);

  state_t                    state;
  logic [ADDR_W-1:0]         count;
  logic [DCNT_W-1:0]         dcnt;
  logic [2:1]                vld_pipe;
  logic signed [DATA_W-1:0]  x_q, w_q;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   acc;
  logic                      accept, last_beat, wr_ok;

  assign accept    = axis.x_tvalid && axis.x_tready;
  assign last_beat = accept && (32'(count) == N_INPUTS - 1);
  // Writes only land while idle, so they never collide with a pipeline read.
  assign wr_ok     = w_wr_en && (state == S_IDLE) && (32'(w_wr_addr) < N_INPUTS);

  neuron_weight_ram #(.DEPTH(N_INPUTS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk(s_axi_aclk), .wr_en(wr_ok), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .rd_en(accept), .rd_addr(count), .rd_data(w_q)
  );

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      vld_pipe <= '0;
      x_q      <= '0;
      prod     <= '0;
      acc      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], accept};
      if (accept)      x_q  <= axis.x_tdata;
      if (vld_pipe[1]) prod <= (2*DATA_W)'(x_q) * (2*DATA_W)'(w_q);
      if (state == S_IDLE && start) acc <= ACC_W'(bias) <<< FRAC_W;
      else if (vld_pipe[2])         acc <= acc + ACC_W'(prod);
    end
  end

  logic signed [ACC_W-1:0]  y_full;
  logic signed [SAT_W-1:0]  y_sat;
  logic signed [DATA_W-1:0] y_clip, y_act;
  logic                     sat_ovf;

  always_comb begin
    y_full = acc >>> FRAC_W;
    y_sat  = saturate(SAT_W'(y_full), DATA_W, sat_ovf);
    y_clip = DATA_W'(y_sat);
    y_act  = y_clip;
    if (y_clip < 0) begin
      if (ACTIVATION == ACT_RELU)       y_act = '0;
      else if (ACTIVATION == ACT_LEAKY) y_act = y_clip >>> 3;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state         <= S_IDLE;
      count         <= '0;
      dcnt          <= '0;
      axis.x_tready <= 1'b0;
      axis.a_tvalid <= 1'b0;
      axis.a_tdata  <= '0;
      busy          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state         <= S_RUN;
          count         <= '0;
          overflow      <= 1'b0;
          axis.x_tready <= 1'b1;
          busy          <= 1'b1;
        end
        S_RUN: if (accept) begin
          count <= count + 1'b1;
          if (last_beat) begin
            state         <= S_DRAIN;
            axis.x_tready <= 1'b0;
            dcnt          <= '0;
          end
        end
        // The last product reaches acc during the final drain cycle.
        S_DRAIN: if (32'(dcnt) == DRAIN_CYCLES - 1) begin
          state         <= S_OUT;
          axis.a_tvalid <= 1'b1;
          axis.a_tdata  <= y_act;
          overflow      <= overflow | sat_ovf;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
        S_OUT: if (axis.a_tready) begin
          state         <= S_IDLE;
          axis.a_tvalid <= 1'b0;
          busy          <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
